// File: rtl/dcache_pkg.sv
// Shared types, field widths and address-field helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int NUM_SETS = 8;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } dcache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Per-line valid/dirty/tag/data storage with a byte-write port, a line-fill
// port and combinational read of the addressed line.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  idx,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_off,
  input  logic [7:0]          byte_wdata,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  output logic                line_valid,
  output logic                line_dirty,
  output logic [TAG_W-1:0]    line_tag,
  output logic [BLOCK_W-1:0]  line_data
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];
  logic [BLOCK_W-1:0]  data_d [NUM_SETS];

  // A fill always leaves the line clean; it takes priority over a byte write.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_we) begin
      data_d[idx]  = fill_data;
      tag_d[idx]   = fill_tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (byte_we) begin
      data_d[idx][{byte_off, 3'b000} +: 8] = byte_wdata;
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: byte hits complete without
// stall, misses write back a dirty victim then fetch the new block.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [7:0]   ADDRESS,
  input  logic [7:0]   WRITEDATA,
  output logic [7:0]   READDATA,
  output logic         BUSYWAIT,
  output logic         mem_read,
  output logic         mem_write,
  output logic [5:0]   mem_address,
  output logic [31:0]  mem_writedata,
  input  logic [31:0]  mem_readdata,
  input  logic         mem_busywait
);

  // CPU handshake: a request (READ or WRITE) is accepted on the cycle BUSYWAIT
  // is low; while BUSYWAIT is high the CPU holds request, address and data.
  // Memory handshake: a transfer is complete on the posedge sampling
  // mem_busywait low while mem_read or mem_write is high.

  dcache_state_e state_q, state_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic [OFFSET_W-1:0] off;
  logic                req, is_rd, is_wr, hit;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                byte_we, fill_we;

  assign idx     = addr_index(ADDRESS);
  assign req_tag = addr_tag(ADDRESS);
  assign off     = addr_offset(ADDRESS);
  assign req     = READ | WRITE;
  assign is_wr   = WRITE;
  assign is_rd   = READ & ~WRITE;
  assign hit     = line_valid && (line_tag == req_tag);
  assign byte_we = (state_q == ST_IDLE) && is_wr && hit;
  assign fill_we = (state_q == ST_FETCH) && !mem_busywait;

  dcache_array u_array (
    .clk        (CLK),
    .rst_n      (RESET),
    .idx        (idx),
    .byte_we    (byte_we),
    .byte_off   (off),
    .byte_wdata (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (req_tag),
    .fill_data  (mem_readdata),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req && !hit) state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FETCH;
      ST_WRITEBACK: if (!mem_busywait) state_d = req ? ST_FETCH : ST_IDLE;
      ST_FETCH:     if (!mem_busywait) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // RESET gates the CPU-side outputs so they drop the instant reset asserts.
  always_comb begin
    mem_read      = (state_q == ST_FETCH);
    mem_write     = (state_q == ST_WRITEBACK);
    mem_address   = '0;
    mem_writedata = '0;
    if (state_q == ST_WRITEBACK) begin
      mem_address   = {line_tag, idx};
      mem_writedata = line_data;
    end else if (state_q == ST_FETCH) begin
      mem_address   = {req_tag, idx};
    end
    BUSYWAIT = RESET && ((state_q != ST_IDLE) || (req && !hit));
    READDATA = '0;
    if (RESET && (state_q == ST_IDLE) && is_rd && hit) READDATA = line_data[{off, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl against a line-level cache
// model and a memory responder with a programmable stall length.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = '0;
  logic [7:0]  WRITEDATA = '0;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_busywait = 1'b0;

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int mem_n = 5;

  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  logic        ref_valid [8];
  logic        ref_dirty [8];
  logic [2:0]  ref_tag [8];
  logic [31:0] ref_line [8];
  logic [7:0]  exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  // Each transfer stalls mem_n cycles, then completes on the following cycle.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!(mem_read || mem_write)) begin
        cnt = 0;
        mem_busywait = 1'b0;
      end else begin
        if (!mem_busywait && cnt > 0) cnt = 1;
        else cnt++;
        mem_busywait = (cnt <= mem_n);
        if (mem_read) mem_readdata = mem_arr[mem_address];
        if (!mem_busywait && mem_write) mem_arr[mem_address] = mem_writedata;
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wd, output int stall, output logic [7:0] got_rd);
    logic [2:0]  idx;
    logic [2:0]  tg;
    logic [1:0]  off;
    int          exp_stall;
    logic        exp_wb;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic        exp_fetch;
    logic        wb_seen, fetch_seen, both_seen;
    logic [5:0]  wb_addr, fetch_addr;
    logic [31:0] wb_data;
    logic [7:0]  exp_rd;

    idx = addr[4:2];
    tg  = addr[7:5];
    off = addr[1:0];
    exp_wb = 1'b0; exp_wb_addr = '0; exp_wb_data = '0; exp_fetch = 1'b0;
    exp_stall = 0;
    if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
      exp_fetch = 1'b1;
      if (ref_valid[idx] && ref_dirty[idx]) begin
        exp_wb      = 1'b1;
        exp_wb_addr = {ref_tag[idx], idx};
        exp_wb_data = ref_line[idx];
        ref_mem[exp_wb_addr] = ref_line[idx];
        exp_stall   = 2 * mem_n + 3;
      end else begin
        exp_stall   = mem_n + 2;
      end
      ref_line[idx]  = ref_mem[{tg, idx}];
      ref_tag[idx]   = tg;
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_line[idx][off*8 +: 8] = wd;
      ref_dirty[idx] = 1'b1;
    end else if (rd) begin
      exp_q.push_back(ref_line[idx][off*8 +: 8]);
    end

    stall = 0;
    wb_seen = 1'b0; fetch_seen = 1'b0; both_seen = 1'b0;
    wb_addr = '0; fetch_addr = '0; wb_data = '0;
    @(posedge CLK);
    #2;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stall++;
      if (mem_read && mem_write) both_seen = 1'b1;
      if (mem_write && !wb_seen) begin
        wb_seen = 1'b1; wb_addr = mem_address; wb_data = mem_writedata;
      end
      if (mem_read && !fetch_seen) begin
        fetch_seen = 1'b1; fetch_addr = mem_address;
      end
    end
    got_rd = READDATA;
    check("busywait_released", BUSYWAIT, 1'b0);
    check("stall_cycles", stall, exp_stall);
    check("rd_wr_exclusive", both_seen, 1'b0);
    check("writeback_seen", wb_seen, exp_wb);
    if (exp_wb) begin
      check("writeback_addr", wb_addr, exp_wb_addr);
      check("writeback_data", wb_data, exp_wb_data);
    end
    check("fetch_seen", fetch_seen, exp_fetch);
    if (exp_fetch) check("fetch_addr", fetch_addr, {tg, idx});
    if (rd && !wr) begin
      exp_rd = exp_q.pop_front();
      check("readdata", got_rd, exp_rd);
    end
    @(posedge CLK);
    #2;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         st;
    logic [7:0] rd_v;
    logic [7:0] a;
    int         op;

    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
    end
    mem_arr[9] = 32'hDDCCBBAA;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_arr[i];
    clear_model();

    // Reset holds every output low even with a request presented.
    READ = 1'b1; ADDRESS = 8'h25;
    #23;
    check("rst_busywait", BUSYWAIT, 1'b0);
    check("rst_readdata", READDATA, 8'h00);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, 6'h00);
    check("rst_mem_writedata", mem_writedata, 32'h0);
    READ = 1'b0;
    @(posedge CLK); #2;
    RESET = 1'b1;

    // Directed walk-through with N = 5.
    mem_n = 5;
    do_access(1'b1, 1'b0, 8'h25, 8'h00, st, rd_v);
    check("t1_clean_miss_rd", rd_v, 8'hBB);
    check("t1_clean_miss_stall", st, 7);
    do_access(1'b1, 1'b0, 8'h25, 8'h00, st, rd_v);
    check("t2_hit_rd_bb", rd_v, 8'hBB);
    do_access(1'b1, 1'b0, 8'h24, 8'h00, st, rd_v);
    check("t2_hit_rd_aa", rd_v, 8'hAA);
    do_access(1'b0, 1'b1, 8'h26, 8'h5A, st, rd_v);
    check("t3_wr_hit_stall", st, 0);
    do_access(1'b1, 1'b0, 8'h26, 8'h00, st, rd_v);
    check("t3_rd_back", rd_v, 8'h5A);
    do_access(1'b1, 1'b0, 8'hA4, 8'h00, st, rd_v);
    check("t4_dirty_miss_stall", st, 13);
    check("t4_mem_victim", mem_arr[9], 32'hDD5ABBAA);

    // Reset in the middle of a fetch.
    @(posedge CLK); #2;
    READ = 1'b1; ADDRESS = 8'h25;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (mem_read) break;
    end
    check("t5_fetch_started", mem_read, 1'b1);
    check("t5_mem_busy_before_rst", mem_busywait, 1'b1);
    #1 RESET = 1'b0;
    #1;
    check("t5_mem_read_drop", mem_read, 1'b0);
    check("t5_busywait_drop", BUSYWAIT, 1'b0);
    check("t5_readdata_zero", READDATA, 8'h00);
    check("t5_mem_address_zero", mem_address, 6'h00);
    READ = 1'b0;
    @(posedge CLK); #2;
    RESET = 1'b1;
    clear_model();
    do_access(1'b1, 1'b0, 8'h25, 8'h00, st, rd_v);
    check("t5_miss_after_reset", st, 7);

    // Store to a cold line: clean miss, then the byte lands and the line is dirty.
    do_access(1'b0, 1'b1, 8'h10, 8'hC3, st, rd_v);
    check("t6_cold_write_stall", st, 7);
    do_access(1'b1, 1'b0, 8'h10, 8'h00, st, rd_v);
    check("t6_cold_write_rd", rd_v, 8'hC3);
    do_access(1'b1, 1'b0, 8'hF0, 8'h00, st, rd_v);
    check("t6_victim_in_mem", mem_arr[6'h04][7:0], 8'hC3);

    // Random traffic over four sets to force conflicts and write-backs.
    for (int t = 0; t < 160; t++) begin
      mem_n = $urandom_range(1, 4);
      a = 8'($urandom_range(0, 255)) & 8'hEF;
      op = $urandom_range(0, 9);
      if (op < 5)      do_access(1'b1, 1'b0, a, 8'h00, st, rd_v);
      else if (op < 9) do_access(1'b0, 1'b1, a, 8'($urandom_range(0, 255)), st, rd_v);
      else             do_access(1'b1, 1'b1, a, 8'($urandom_range(0, 255)), st, rd_v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
